// File: rtl/m_watch_display_scan.sv
// m_watch_display_scan
//   Scans the watch's BCD hour/min/sec onto a 6-digit multiplexed
//   common-anode 7-segment display. One digit is shown per slot, and each slot
//   begins with a one-clock blank gap to avoid ghosting. The time is
//   snapshotted once per frame, and only when two consecutive samples agree.
//   In set mode the hour and minute digits blink.
// Ports
//   clk        board clock
//   reset      asynchronous, active-high
//   hour/min/sec  BCD {tens,ones}, asynchronous to clk
//   mode       0 = display, 1 = set (blink hour/min); asynchronous
//   seg_n      segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n       decimal point, active-low, registered
//   dig_n      digit enables, active-low, bit i = slot i, registered
//   frame_tick one-clock pulse after the last slot of a frame
module m_watch_display_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 12500000,
   parameter bit LZ_BLANK  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] hour,
   input  logic [7:0] min,
   input  logic [7:0] sec,
   input  logic       mode,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [5:0] dig_n,
   output logic       frame_tick
);
   localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [2:0]    slot;
   logic [23:0]   samp, snap;
   logic          mode_s1, mode_s2, mode_q;
   logic [BW-1:0] bcnt;
   logic          blink_on;

   logic [23:0] live;
   logic        tick, frame_end, mode_rise, bwrap;
   assign live      = {hour, min, sec};
   assign tick      = (cnt == CW'(SCAN_DIV - 1));
   assign frame_end = tick && (slot == 3'd5);
   assign mode_rise = mode_s2 && !mode_q;
   assign bwrap     = (bcnt == BW'(BLINK_DIV - 1));

   function automatic logic [6:0] seg_dec(input logic [3:0] d);
      case (d)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b0111111;  // non-BCD shows a dash
      endcase
   endfunction

   // Slot prescaler and frame counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         slot       <= 3'd0;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= tick ? '0 : cnt + 1'b1;
         frame_tick <= frame_end;
         if (tick) slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      end
   end

   // Tear-free snapshot: samp and the live inputs must agree at the frame
   // end, otherwise the watch was mid-update and we retry next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp <= '0;
         snap <= '0;
      end else begin
         samp <= live;
         if (frame_end && (samp == live)) snap <= samp;
      end
   end

   // mode synchronizer and blink timer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_s1  <= 1'b0;
         mode_s2  <= 1'b0;
         mode_q   <= 1'b0;
         bcnt     <= '0;
         blink_on <= 1'b1;
      end else begin
         mode_s1 <= mode;
         mode_s2 <= mode_s1;
         mode_q  <= mode_s2;
         if (mode_rise) begin
            // restart the blink phase so digits are lit on entering set mode
            bcnt     <= '0;
            blink_on <= 1'b1;
         end else begin
            bcnt <= bwrap ? '0 : bcnt + 1'b1;
            if (!mode_s2)   blink_on <= 1'b1;
            else if (bwrap) blink_on <= !blink_on;
         end
      end
   end

   // Next-output decode from the current cnt/slot
   logic [3:0] nib;
   logic       blank, enabled;
   logic [6:0] seg_d;
   logic [5:0] dig_d;
   logic       dp_d;

   always_comb begin
      nib = 4'd0;
      case (slot)
         3'd0:    nib = snap[3:0];
         3'd1:    nib = snap[7:4];
         3'd2:    nib = snap[11:8];
         3'd3:    nib = snap[15:12];
         3'd4:    nib = snap[19:16];
         3'd5:    nib = snap[23:20];
         default: nib = 4'd0;
      endcase
      blank = (LZ_BLANK && (slot == 3'd5) && (nib == 4'd0)) ||
              (mode_s2 && !blink_on && (slot >= 3'd2) && (slot <= 3'd5));
      enabled = (cnt != '0) && !blank;
      seg_d   = blank ? 7'h7F : seg_dec(nib);
      dig_d   = enabled ? ~(6'd1 << slot) : 6'h3F;
      dp_d    = !(enabled && !mode_s2 && ((slot == 3'd2) || (slot == 3'd4)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_n <= 7'h7F;
         dig_n <= 6'h3F;
         dp_n  <= 1'b1;
      end else begin
         seg_n <= seg_d;
         dig_n <= dig_d;
         dp_n  <= dp_d;
      end
   end
endmodule

// File: tb/tb_m_watch_display_scan.sv
module tb_m_watch_display_scan;
   logic clk = 1'b0;
   logic reset;
   logic [7:0] hour, min, sec;
   logic mode;
   logic [6:0] seg0, seg1;
   logic dp0, dp1, ft0, ft1;
   logic [5:0] dig0, dig1;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // dut0: leading-zero blanking on; dut1: off. Both share inputs.
   m_watch_display_scan #(.SCAN_DIV(4), .BLINK_DIV(40), .LZ_BLANK(1'b1)) dut0 (
      .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec), .mode(mode),
      .seg_n(seg0), .dp_n(dp0), .dig_n(dig0), .frame_tick(ft0));
   m_watch_display_scan #(.SCAN_DIV(4), .BLINK_DIV(40), .LZ_BLANK(1'b0)) dut1 (
      .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec), .mode(mode),
      .seg_n(seg1), .dp_n(dp1), .dig_n(dig1), .frame_tick(ft1));

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_time(input logic [23:0] t);
      {hour, min, sec} = t;
   endtask

   // Leaves the bench at the negedge where frame_tick is high.
   task automatic wait_frame(input bit skip_now);
      int n = 0;
      if (skip_now) step();
      while (!ft0 && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (ft0 !== 1'b1) begin
         failures++;
         $display("FAIL wait_frame: frame_tick=%b required 1 within 200 clocks", ft0);
      end
   endtask

   // Checks the 24 clocks that follow a frame boundary; both DUTs.
   task automatic scan_frame(input logic [23:0] t, input string tag);
      for (int j = 1; j <= 24; j++) begin
         int s, c;
         logic [3:0] nib;
         step();
         s = (j - 1) / 4;
         c = (j - 1) % 4;
         nib = t[4*s +: 4];
         for (int d = 0; d < 2; d++) begin
            logic [6:0] sg, esg;
            logic [5:0] dg, edg;
            logic dp, edp, ft, eft;
            bit blank;
            sg = d ? seg1 : seg0;
            dg = d ? dig1 : dig0;
            dp = d ? dp1  : dp0;
            ft = d ? ft1  : ft0;
            blank = (d == 0) && (s == 5) && (nib == 4'd0);
            edg = (c == 0 || blank) ? 6'h3F : ~(6'd1 << s);
            esg = blank ? 7'h7F : seg_of(nib);
            edp = (c != 0 && !blank && (s == 2 || s == 4)) ? 1'b0 : 1'b1;
            eft = (j == 24);
            checks++;
            if (dg !== edg) begin
               failures++;
               $display("FAIL %s dig_n dut%0d slot%0d cnt%0d: got %b want %b", tag, d, s, c, dg, edg);
            end
            checks++;
            if (dp !== edp) begin
               failures++;
               $display("FAIL %s dp_n dut%0d slot%0d cnt%0d: got %b want %b", tag, d, s, c, dp, edp);
            end
            checks++;
            if (ft !== eft) begin
               failures++;
               $display("FAIL %s frame_tick dut%0d j%0d: got %b want %b", tag, d, j, ft, eft);
            end
            if (c != 0) begin
               checks++;
               if (sg !== esg) begin
                  failures++;
                  $display("FAIL %s seg_n dut%0d slot%0d cnt%0d: got %b want %b", tag, d, s, c, sg, esg);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mode  = 1'b0;
      set_time(24'h123456);
      repeat (3) step();
      checks++;
      if ({seg0, dp0, dig0, ft0} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
         failures++;
         $display("FAIL reset dut0: got seg=%h dp=%b dig=%h ft=%b", seg0, dp0, dig0, ft0);
      end
      checks++;
      if ({seg1, dp1, dig1, ft1} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
         failures++;
         $display("FAIL reset dut1: got seg=%h dp=%b dig=%h ft=%b", seg1, dp1, dig1, ft1);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      wait_frame(1'b0);
      scan_frame(24'h123456, "basic");
   endtask

   task automatic test_lz_blank();
      set_time(24'h073456);
      wait_frame(1'b1);
      scan_frame(24'h073456, "lz_blank");
   endtask

   task automatic test_dash();
      set_time(24'h12345A);
      wait_frame(1'b1);
      scan_frame(24'h12345A, "dash");
   endtask

   task automatic test_snapshot();
      // Inputs change every clock across the frame end: snap must hold.
      for (int k = 0; k < 24; k++) begin
         set_time((k % 2) ? 24'h112233 : 24'h234501);
         step();
      end
      set_time(24'h090807);
      wait_frame(1'b0);
      scan_frame(24'h12345A, "snap_hold");
      wait_frame(1'b0);
      scan_frame(24'h090807, "snap_load");
   endtask

   task automatic test_blink();
      set_time(24'h123456);
      wait_frame(1'b1);
      mode = 1'b1;
      for (int j = 1; j <= 163; j++) begin
         step();
         if (j >= 3) begin
            int s, c;
            bit vis, blank;
            logic [5:0] edg;
            s = ((j - 1) / 4) % 6;
            c = (j - 1) % 4;
            vis = (j < 44) || ((((j - 4) / 40) % 2) == 0);
            blank = !vis && (s >= 2);
            edg = (c == 0 || blank) ? 6'h3F : ~(6'd1 << s);
            checks++;
            if (dig0 !== edg || dig1 !== edg) begin
               failures++;
               $display("FAIL blink dig_n j%0d slot%0d: got %b/%b want %b", j, s, dig0, dig1, edg);
            end
            checks++;
            if (dp0 !== 1'b1 || dp1 !== 1'b1) begin
               failures++;
               $display("FAIL blink dp_n j%0d: got %b/%b want 1", j, dp0, dp1);
            end
            if (c != 0 && blank) begin
               checks++;
               if (seg0 !== 7'h7F) begin
                  failures++;
                  $display("FAIL blink seg_n j%0d: got %b want 1111111", j, seg0);
               end
            end
         end
      end
      mode = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_mid_reset();
      wait_frame(1'b1);
      repeat (14) step();  // now in slot 3, cnt 1
      reset = 1'b1;
      #1;
      checks++;
      if ({seg0, dig0, dp0, ft0} !== {7'h7F, 6'h3F, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset dut0: got seg=%h dig=%h dp=%b ft=%b", seg0, dig0, dp0, ft0);
      end
      checks++;
      if ({seg1, dig1} !== {7'h7F, 6'h3F}) begin
         failures++;
         $display("FAIL mid_reset dut1: got seg=%h dig=%h", seg1, dig1);
      end
      @(negedge clk);
      reset = 1'b0;
      // snap was cleared, so 00:00:00 from slot 0, cnt 0
      scan_frame(24'h000000, "post_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lz_blank();
      test_dash();
      test_snapshot();
      test_blink();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
